// File: rtl/triangle_stream_fifo_if.sv
// Handshake bundle for triangle_stream_fifo: producer side (in_*) and
// consumer side (out_*) of the triangle stream.
//   in_valid/in_ready/in_tri    : producer -> FIFO
//   out_valid/out_ready/out_tri : FIFO -> consumer (first-word-fall-through)
// Modport slave is the FIFO's view; master is the environment's view.
interface triangle_stream_fifo_if #(
    parameter int WI = 8,
    parameter int WF = 8
);
    localparam int W = WI + WF;

    logic                   in_valid;
    logic                   in_ready;
    logic [2:0][2:0][W-1:0] in_tri;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0][2:0][W-1:0] out_tri;

    modport master (
        output in_valid,
        output in_tri,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_tri
    );

    modport slave (
        input  in_valid,
        input  in_tri,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_tri
    );
endinterface

// File: rtl/triangle_stream_fifo.sv
// Triangle FIFO between transform stage and rasteriser: FWFT output,
// any depth, almost-full/empty flags, occupancy, flush, high-water mark.
// Ports:
//   Clk, Reset_n   : clock, async active-low reset
//   flush          : synchronous clear, beats push/pop
//   bus (slave)    : in_valid/in_ready/in_tri, out_valid/out_ready/out_tri
//   count          : occupancy
//   almost_full    : count >= AF_LEVEL
//   almost_empty   : count <= AE_LEVEL
//   max_count      : high-water mark since reset/flush
module triangle_stream_fifo #(
    parameter int WI       = 8,
    parameter int WF       = 8,
    parameter int DEPTH    = 10,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   flush,
    triangle_stream_fifo_if.slave  bus,
    output logic [CW-1:0]          count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [CW-1:0]          max_count
);
    localparam int W  = WI + WF;
    localparam int PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef logic [2:0][2:0][W-1:0] tri_t;

    tri_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_max;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;

    // Ready depends on registered count only: a full FIFO refuses a
    // push even while the consumer pops in the same cycle.
    assign w_in_ready  = (r_count != FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = bus.out_ready & w_out_valid;

    // Non-power-of-two depth: wrap by explicit compare.
    assign w_wr_nxt = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_max    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_max    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            r_count <= w_count_nxt;
            if (w_count_nxt > r_max) begin
                r_max <= w_count_nxt;
            end
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge Clk) begin
        if (Reset_n && !flush && w_push) begin
            r_mem[r_wr_ptr] <= bus.in_tri;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_tri   = w_out_valid ? r_mem[r_rd_ptr] : '0;

    assign count        = r_count;
    assign max_count    = r_max;
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);
endmodule
